// File: rtl/alu_pkg.sv
// ALU operation encodings shared by the controller and the datapath ALU.
// Immediate-ALU and branch encodings equal their instruction opcodes, so the
// controller can cast the opcode field straight onto the ALU select.
package alu_pkg;

    typedef enum logic [5:0] {
        ALU_RTYPE = 6'h00,  // operation chosen by the funct field
        ALU_BEQ   = 6'h04,
        ALU_BNE   = 6'h05,
        ALU_BLEZ  = 6'h06,
        ALU_BGTZ  = 6'h07,
        ALU_ADDIU = 6'h09,
        ALU_SLTI  = 6'h0A,
        ALU_SLTIU = 6'h0B,
        ALU_ANDI  = 6'h0C,
        ALU_ORI   = 6'h0D,
        ALU_XORI  = 6'h0E
    } alu_op_sel_t;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields in, every mux select,
// write enable and ALU select out. master = controller, slave = datapath.
interface mips_mc_controller_if;
    import alu_pkg::*;

    logic [5:0]  ir_31_26;
    logic [5:0]  ir_5_to_0;
    logic        pc_write_cond;
    logic        pc_write;
    logic        i_or_d;
    logic        mem_write;
    logic        mem_to_reg;
    logic        ir_write;
    logic        jump_and_link;
    logic        is_signed;
    logic        alu_src_a;
    logic        reg_write;
    logic        reg_dst;
    logic [1:0]  pc_source;
    logic [1:0]  alu_src_b;
    alu_op_sel_t alu_op;
    logic        halted;

    modport master (
        input  ir_31_26, ir_5_to_0,
        output pc_write_cond, pc_write, i_or_d, mem_write, mem_to_reg,
               ir_write, jump_and_link, is_signed, alu_src_a, reg_write,
               reg_dst, pc_source, alu_src_b, alu_op, halted
    );

    modport slave (
        output ir_31_26, ir_5_to_0,
        input  pc_write_cond, pc_write, i_or_d, mem_write, mem_to_reg,
               ir_write, jump_and_link, is_signed, alu_src_a, reg_write,
               reg_dst, pc_source, alu_src_b, alu_op, halted
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM with a configurable memory read latency.
// Outputs are Moore-style from the state, qualified by the IR fields.
module mips_mc_controller
    import alu_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 1,   // 1..15
    parameter int WIDTH           = 32   // datapath width, not used here
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_mc_controller_if.master  ctl
);

    localparam int WCNT_W = $clog2(MEM_WAIT_CYCLES + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [3:0] {
        FETCH1, FETCH_WAIT, DECODE, R_EXEC, R_WB, IMM_EXEC, IMM_WB,
        MEM_ADDR, LW_WAIT, LW_WB, SW_ACCESS, BRANCH, JUMP, JR_EXEC, HALT
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [WCNT_W-1:0]   wcnt_reg;
    logic                last_wait;

    // Out-of-range parameters leave this marker block in the hierarchy,
    // which makes a bad build easy to spot in the elaborated netlist.
    generate
        if (MEM_WAIT_CYCLES < 1 || MEM_WAIT_CYCLES > 15 || WIDTH < 1) begin : g_param_out_of_range
        end
    endgenerate

    assign last_wait = (wcnt_reg == WCNT_W'(MEM_WAIT_CYCLES - 1));

    // State register; reset aborts any instruction and restarts at FETCH1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH1;
        end else begin
            state_reg <= state_next;
        end
    end

    // Memory wait counter: runs only inside the wait states, zero elsewhere,
    // so it is always clear on entry to FETCH_WAIT / LW_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_reg <= '0;
        end else if ((state_reg == FETCH_WAIT || state_reg == LW_WAIT) && !last_wait) begin
            wcnt_reg <= wcnt_reg + WCNT_W'(1);
        end else begin
            wcnt_reg <= '0;
        end
    end

    // Next-state decode and datapath control outputs.
    always_comb begin
        state_next        = state_reg;
        ctl.pc_write_cond = 1'b0;
        ctl.pc_write      = 1'b0;
        ctl.i_or_d        = 1'b0;
        ctl.mem_write     = 1'b0;
        ctl.mem_to_reg    = 1'b0;
        ctl.ir_write      = 1'b0;
        ctl.jump_and_link = 1'b0;
        ctl.is_signed     = 1'b0;
        ctl.alu_src_a     = 1'b0;
        ctl.reg_write     = 1'b0;
        ctl.reg_dst       = 1'b0;
        ctl.pc_source     = 2'b00;
        ctl.alu_src_b     = 2'b00;
        ctl.alu_op        = ALU_ADDIU;
        ctl.halted        = 1'b0;

        case (state_reg)
            FETCH1: begin
                ctl.alu_src_b = 2'b01;          // PC <= PC + 4
                ctl.pc_write  = 1'b1;
                state_next    = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (last_wait) begin
                    ctl.ir_write = 1'b1;        // read data valid this cycle
                    state_next   = DECODE;
                end
            end
            DECODE: begin
                ctl.alu_src_b = 2'b11;          // ALUOut <= PC + (sext(imm) << 2)
                ctl.is_signed = 1'b1;
                case (ctl.ir_31_26)
                    OP_RTYPE: state_next = (ctl.ir_5_to_0 == FN_JR) ? JR_EXEC : R_EXEC;
                    OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_XORI:   state_next = IMM_EXEC;
                    OP_LW, OP_SW:               state_next = MEM_ADDR;
                    OP_BEQ, OP_BNE,
                    OP_BLEZ, OP_BGTZ:           state_next = BRANCH;
                    OP_J, OP_JAL:               state_next = JUMP;
                    default:                    state_next = HALT;
                endcase
            end
            R_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALU_RTYPE;
                state_next    = R_WB;
            end
            R_WB: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
                state_next    = FETCH1;
            end
            IMM_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.alu_op    = alu_op_sel_t'(ctl.ir_31_26);
                // logical immediates are zero-extended
                ctl.is_signed = !(ctl.ir_31_26 == OP_ANDI || ctl.ir_31_26 == OP_ORI ||
                                  ctl.ir_31_26 == OP_XORI);
                state_next    = IMM_WB;
            end
            IMM_WB: begin
                ctl.reg_write = 1'b1;
                state_next    = FETCH1;
            end
            MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.is_signed = 1'b1;
                state_next    = (ctl.ir_31_26 == OP_LW) ? LW_WAIT : SW_ACCESS;
            end
            LW_WAIT: begin
                ctl.i_or_d = 1'b1;
                if (last_wait) begin
                    state_next = LW_WB;
                end
            end
            LW_WB: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
                state_next     = FETCH1;
            end
            SW_ACCESS: begin
                ctl.i_or_d    = 1'b1;
                ctl.mem_write = 1'b1;
                state_next    = FETCH1;
            end
            BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = alu_op_sel_t'(ctl.ir_31_26);
                ctl.pc_source     = 2'b01;
                ctl.pc_write_cond = 1'b1;
                state_next        = FETCH1;
            end
            JUMP: begin
                ctl.pc_source = 2'b10;
                ctl.pc_write  = 1'b1;
                if (ctl.ir_31_26 == OP_JAL) begin
                    ctl.jump_and_link = 1'b1;
                    ctl.reg_write     = 1'b1;
                end
                state_next = FETCH1;
            end
            JR_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALU_RTYPE;
                ctl.pc_source = 2'b00;
                ctl.pc_write  = 1'b1;
                state_next    = FETCH1;
            end
            HALT: begin
                ctl.halted = 1'b1;
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench: two controllers (W=1 and W=3). For each instruction
// the expected per-cycle control vectors are queued, then popped and compared
// against the DUT outputs at every falling edge.
module tb_mips_mc_controller;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       jump_and_link;
        logic       is_signed;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       halted;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [5:0] alu_op;
    } ctl_t;

    logic clk;
    logic rst1;
    logic rst3;
    int   n_tests;
    int   n_fail;
    ctl_t exp_q[$];
    ctl_t obs1;
    ctl_t obs3;

    mips_mc_controller_if bus1();
    mips_mc_controller_if bus3();

    mips_mc_controller #(.MEM_WAIT_CYCLES(1), .WIDTH(32)) dut1 (
        .clk (clk),
        .rst (rst1),
        .ctl (bus1)
    );

    mips_mc_controller #(.MEM_WAIT_CYCLES(3), .WIDTH(32)) dut3 (
        .clk (clk),
        .rst (rst3),
        .ctl (bus3)
    );

    assign obs1 = {bus1.pc_write_cond, bus1.pc_write, bus1.i_or_d, bus1.mem_write,
                   bus1.mem_to_reg, bus1.ir_write, bus1.jump_and_link, bus1.is_signed,
                   bus1.alu_src_a, bus1.reg_write, bus1.reg_dst, bus1.halted,
                   bus1.pc_source, bus1.alu_src_b, 6'(bus1.alu_op)};
    assign obs3 = {bus3.pc_write_cond, bus3.pc_write, bus3.i_or_d, bus3.mem_write,
                   bus3.mem_to_reg, bus3.ir_write, bus3.jump_and_link, bus3.is_signed,
                   bus3.alu_src_a, bus3.reg_write, bus3.reg_dst, bus3.halted,
                   bus3.pc_source, bus3.alu_src_b, 6'(bus3.alu_op)};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t base_ctl();
        ctl_t v;
        v        = '0;
        v.alu_op = 6'h09;
        return v;
    endfunction

    function automatic ctl_t fetch1_ctl();
        ctl_t v;
        v           = base_ctl();
        v.pc_write  = 1'b1;
        v.alu_src_b = 2'b01;
        return v;
    endfunction

    // Expected per-cycle controls of one instruction.
    task automatic push_expected(input int w, input logic [5:0] op, input logic [5:0] fn,
                                 input int halt_cycles);
        ctl_t v;
        exp_q.push_back(fetch1_ctl());
        for (int i = 0; i < w; i++) begin
            v          = base_ctl();
            v.ir_write = (i == w - 1);
            exp_q.push_back(v);
        end
        v           = base_ctl();
        v.alu_src_b = 2'b11;
        v.is_signed = 1'b1;
        exp_q.push_back(v);
        case (op)
            6'h00: begin
                if (fn == 6'h08) begin
                    v           = base_ctl();
                    v.alu_src_a = 1'b1;
                    v.alu_op    = 6'h00;
                    v.pc_write  = 1'b1;
                    exp_q.push_back(v);
                end else begin
                    v           = base_ctl();
                    v.alu_src_a = 1'b1;
                    v.alu_op    = 6'h00;
                    exp_q.push_back(v);
                    v           = base_ctl();
                    v.reg_dst   = 1'b1;
                    v.reg_write = 1'b1;
                    exp_q.push_back(v);
                end
            end
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                v           = base_ctl();
                v.alu_src_a = 1'b1;
                v.alu_src_b = 2'b10;
                v.alu_op    = op;
                v.is_signed = (op == 6'h09 || op == 6'h0A || op == 6'h0B);
                exp_q.push_back(v);
                v           = base_ctl();
                v.reg_write = 1'b1;
                exp_q.push_back(v);
            end
            6'h23, 6'h2B: begin
                v           = base_ctl();
                v.alu_src_a = 1'b1;
                v.alu_src_b = 2'b10;
                v.is_signed = 1'b1;
                exp_q.push_back(v);
                if (op == 6'h23) begin
                    for (int i = 0; i < w; i++) begin
                        v        = base_ctl();
                        v.i_or_d = 1'b1;
                        exp_q.push_back(v);
                    end
                    v            = base_ctl();
                    v.mem_to_reg = 1'b1;
                    v.reg_write  = 1'b1;
                    exp_q.push_back(v);
                end else begin
                    v           = base_ctl();
                    v.i_or_d    = 1'b1;
                    v.mem_write = 1'b1;
                    exp_q.push_back(v);
                end
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                v               = base_ctl();
                v.alu_src_a     = 1'b1;
                v.alu_op        = op;
                v.pc_source     = 2'b01;
                v.pc_write_cond = 1'b1;
                exp_q.push_back(v);
            end
            6'h02, 6'h03: begin
                v               = base_ctl();
                v.pc_source     = 2'b10;
                v.pc_write      = 1'b1;
                v.jump_and_link = (op == 6'h03);
                v.reg_write     = (op == 6'h03);
                exp_q.push_back(v);
            end
            default: begin
                for (int i = 0; i < halt_cycles; i++) begin
                    v        = base_ctl();
                    v.halted = 1'b1;
                    exp_q.push_back(v);
                end
            end
        endcase
    endtask

    // One transaction: load IR fields, queue expectations, compare each cycle.
    // stop_after > 0 checks only the first cycles (used before a mid-flight reset).
    task automatic run_instr(input int w, input logic [5:0] op, input logic [5:0] fn,
                             input int halt_cycles, input int stop_after);
        ctl_t e;
        ctl_t got;
        int   ncyc;
        int   fails_before;
        fails_before = n_fail;
        if (w == 1) begin
            bus1.ir_31_26  = op;
            bus1.ir_5_to_0 = fn;
        end else begin
            bus3.ir_31_26  = op;
            bus3.ir_5_to_0 = fn;
        end
        push_expected(w, op, fn, halt_cycles);
        ncyc = (stop_after > 0) ? stop_after : exp_q.size();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            got = (w == 1) ? obs1 : obs3;
            check_eq($sformatf("w%0d_op%02h_fn%02h_cyc%0d", w, op, fn, i + 1),
                     32'(got), 32'(e));
        end
        exp_q.delete();
        $display("[TB] W=%0d op=%02h funct=%02h cycles=%0d errors=%0d",
                 w, op, fn, ncyc, n_fail - fails_before);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst1           = 1'b1;
        rst3           = 1'b1;
        bus1.ir_31_26  = 6'h00;
        bus1.ir_5_to_0 = 6'h00;
        bus3.ir_31_26  = 6'h00;
        bus3.ir_5_to_0 = 6'h00;

        // ---- W = 1 controller ----
        @(posedge clk);
        #1;
        check_eq("reset_w1", 32'(obs1), 32'(fetch1_ctl()));
        check_eq("reset_w3", 32'(obs3), 32'(fetch1_ctl()));
        rst1 = 1'b0;

        run_instr(1, 6'h00, 6'h21, 0, 0);   // ADDU
        run_instr(1, 6'h0D, 6'h00, 0, 0);   // ORI
        run_instr(1, 6'h09, 6'h00, 0, 0);   // ADDIU
        run_instr(1, 6'h0A, 6'h00, 0, 0);   // SLTI
        run_instr(1, 6'h0B, 6'h00, 0, 0);   // SLTIU
        run_instr(1, 6'h0C, 6'h00, 0, 0);   // ANDI
        run_instr(1, 6'h0E, 6'h00, 0, 0);   // XORI
        run_instr(1, 6'h04, 6'h00, 0, 0);   // BEQ
        run_instr(1, 6'h05, 6'h00, 0, 0);   // BNE
        run_instr(1, 6'h06, 6'h00, 0, 0);   // BLEZ
        run_instr(1, 6'h07, 6'h00, 0, 0);   // BGTZ
        run_instr(1, 6'h02, 6'h00, 0, 0);   // J
        run_instr(1, 6'h03, 6'h00, 0, 0);   // JAL
        run_instr(1, 6'h00, 6'h08, 0, 0);   // JR
        run_instr(1, 6'h2B, 6'h00, 0, 0);   // SW
        run_instr(1, 6'h23, 6'h00, 0, 0);   // LW
        run_instr(1, 6'h00, 6'h2A, 0, 0);   // SLT
        run_instr(1, 6'h3F, 6'h00, 20, 0);  // HALT

        // reset recovers from HALT
        rst1 = 1'b1;
        #1;
        check_eq("halt_reset_w1", 32'(obs1), 32'(fetch1_ctl()));
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        run_instr(1, 6'h00, 6'h21, 0, 0);   // ADDU after recovery
        run_instr(1, 6'h3B, 6'h00, 20, 0);  // undefined opcode
        rst1 = 1'b1;

        // ---- W = 3 controller ----
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        run_instr(3, 6'h23, 6'h00, 0, 0);   // LW, 10 cycles
        run_instr(3, 6'h2B, 6'h00, 0, 0);   // SW
        run_instr(3, 6'h00, 6'h21, 0, 0);   // ADDU
        run_instr(3, 6'h04, 6'h00, 0, 0);   // BEQ
        run_instr(3, 6'h23, 6'h00, 0, 7);   // LW, stop inside LW_WAIT

        // reset held 3 cycles mid-LW: FETCH1 controls, no write pulses
        rst3 = 1'b1;
        #1;
        check_eq("midlw_reset_now", 32'(obs3), 32'(fetch1_ctl()));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("midlw_reset_hold%0d", i), 32'(obs3), 32'(fetch1_ctl()));
        end
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        run_instr(3, 6'h23, 6'h00, 0, 0);   // LW restarts cleanly
        run_instr(3, 6'h03, 6'h00, 0, 0);   // JAL
        run_instr(3, 6'h0D, 6'h00, 0, 0);   // ORI
        run_instr(3, 6'h3F, 6'h00, 20, 0);  // HALT
        rst3 = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
